// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM arbiter: state encoding, bus constants
// and the DSACK completion helper.
package dram_pkg;

  localparam int ADDR_W = 28;

  localparam logic [1:0] SIZ_LONG   = 2'b00;
  localparam logic [1:0] DSACK_DONE = 2'b11;
  localparam logic [1:0] DSACK_IDLE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CPU_RUN = 2'b01,
    ST_DMA_RUN = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_e;

  // Partial acknowledges (01/10) never count as completion.
  function automatic logic dsack_done(input logic [1:0] dsack);
    return (dsack == DSACK_DONE);
  endfunction

endpackage

// File: rtl/dram_arb_timer.sv
// Loadable up-counter with clear/enable and an expire flag when the count
// reaches a programmable limit.
module dram_arb_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Counter register: clear has priority over load, load over count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= {W{1'b0}};
    end else if (i_clr) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = (r_count == i_limit);

endmodule

// File: rtl/dram_arb.sv
// Two-master (CPU / DMA) arbiter in front of the DRAM controller with a
// bounded CPU streak under DMA contention and a per-cycle DSACK timeout.
module dram_arb
  import dram_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cpu_nCS,
  input  logic              cpu_nAS,
  input  logic              cpu_RnW,
  input  logic [1:0]        cpu_SIZ,
  input  logic [ADDR_W-1:0] cpu_ADDR,
  output logic [1:0]        cpu_DSACK,
  output logic              cpu_BERR,
  input  logic              dma_req,
  input  logic              dma_RnW,
  input  logic [ADDR_W-1:0] dma_ADDR,
  output logic              dma_ack,
  output logic              dma_err,
  output logic              mem_nCS,
  output logic              mem_nAS,
  output logic              mem_RnW,
  output logic [1:0]        mem_SIZ,
  output logic [ADDR_W-1:0] mem_ADDR,
  input  logic [1:0]        mem_DSACK
);

  localparam int STREAK_W = $clog2(MAX_CPU_STREAK + 1);
  localparam int TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
  localparam logic [TMR_W-1:0]    TMR_LIMIT  = TMR_W'(TIMEOUT_CYC);

  arb_state_e          r_state,   w_nxt_state;
  logic [STREAK_W-1:0] r_streak,  w_nxt_streak;
  logic                r_mem_ncs, w_nxt_mem_ncs;
  logic                r_mem_nas, w_nxt_mem_nas;
  logic                r_mem_rnw, w_nxt_mem_rnw;
  logic [1:0]          r_mem_siz, w_nxt_mem_siz;
  logic [ADDR_W-1:0]   r_mem_addr, w_nxt_mem_addr;
  logic [1:0]          r_cpu_dsack, w_nxt_cpu_dsack;
  logic                r_cpu_berr, w_nxt_cpu_berr;
  logic                r_dma_ack, w_nxt_dma_ack;
  logic                r_dma_err, w_nxt_dma_err;

  logic w_cpu_go;
  logic w_done;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;

  assign w_cpu_go = ~cpu_nCS & ~cpu_nAS;
  assign w_done   = dsack_done(mem_DSACK);

  dram_arb_timer #(
    .W (TMR_W)
  ) u_timer (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_clr      (w_tmr_clr),
    .i_load     (1'b0),
    .i_load_val ({TMR_W{1'b0}}),
    .i_en       (w_tmr_en),
    .i_limit    (TMR_LIMIT),
    .o_expire   (w_expire)
  );

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_streak    = r_streak;
    w_nxt_mem_ncs   = r_mem_ncs;
    w_nxt_mem_nas   = r_mem_nas;
    w_nxt_mem_rnw   = r_mem_rnw;
    w_nxt_mem_siz   = r_mem_siz;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_cpu_dsack = r_cpu_dsack;
    w_nxt_cpu_berr  = r_cpu_berr;
    w_nxt_dma_ack   = 1'b0;
    w_nxt_dma_err   = 1'b0;
    w_tmr_clr       = 1'b0;
    w_tmr_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cpu_go && (!dma_req || (r_streak < STREAK_MAX))) begin
          w_nxt_state     = ST_CPU_RUN;
          w_nxt_mem_ncs   = 1'b0;
          w_nxt_mem_nas   = 1'b0;
          w_nxt_mem_rnw   = cpu_RnW;
          w_nxt_mem_siz   = cpu_SIZ;
          w_nxt_mem_addr  = cpu_ADDR;
          w_nxt_cpu_dsack = DSACK_IDLE;
          w_tmr_clr       = 1'b1;
          if (dma_req) begin
            w_nxt_streak = r_streak + STREAK_ONE;
          end else begin
            w_nxt_streak = {STREAK_W{1'b0}};
          end
        end else if (dma_req) begin
          w_nxt_state    = ST_DMA_RUN;
          w_nxt_streak   = {STREAK_W{1'b0}};
          w_nxt_mem_ncs  = 1'b0;
          w_nxt_mem_nas  = 1'b0;
          w_nxt_mem_rnw  = dma_RnW;
          w_nxt_mem_siz  = SIZ_LONG;
          w_nxt_mem_addr = dma_ADDR;
          w_tmr_clr      = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end

      ST_CPU_RUN: begin
        // Completed DSACK is held to the CPU until it drops nAS.
        if (w_done) begin
          if (cpu_nAS) begin
            w_nxt_state     = ST_RELEASE;
            w_nxt_mem_ncs   = 1'b1;
            w_nxt_mem_nas   = 1'b1;
            w_nxt_cpu_dsack = DSACK_IDLE;
          end else begin
            w_nxt_cpu_dsack = mem_DSACK;
          end
        end else if (w_expire) begin
          w_nxt_state     = ST_RELEASE;
          w_nxt_mem_ncs   = 1'b1;
          w_nxt_mem_nas   = 1'b1;
          w_nxt_cpu_dsack = DSACK_IDLE;
          w_nxt_cpu_berr  = ~cpu_nAS;
        end else begin
          w_tmr_en = 1'b1;
          if (cpu_nAS) begin
            w_nxt_cpu_dsack = DSACK_IDLE;
          end else begin
            w_nxt_cpu_dsack = mem_DSACK;
          end
        end
      end

      ST_DMA_RUN: begin
        if (w_done) begin
          w_nxt_state   = ST_RELEASE;
          w_nxt_mem_ncs = 1'b1;
          w_nxt_mem_nas = 1'b1;
          w_nxt_dma_ack = 1'b1;
        end else if (w_expire) begin
          w_nxt_state   = ST_RELEASE;
          w_nxt_mem_ncs = 1'b1;
          w_nxt_mem_nas = 1'b1;
          w_nxt_dma_err = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end

      ST_RELEASE: begin
        // Leaving is gated on an outstanding BERR so the CPU is not regranted.
        if (r_cpu_berr && cpu_nAS) begin
          w_nxt_cpu_berr = 1'b0;
        end else begin
          w_nxt_cpu_berr = r_cpu_berr;
        end
        if ((mem_DSACK == DSACK_IDLE) && (!r_cpu_berr || cpu_nAS)) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_state = ST_RELEASE;
        end
      end

      default: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_mem_ncs = 1'b1;
        w_nxt_mem_nas = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_streak    <= {STREAK_W{1'b0}};
      r_mem_ncs   <= 1'b1;
      r_mem_nas   <= 1'b1;
      r_mem_rnw   <= 1'b1;
      r_mem_siz   <= 2'b00;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_cpu_dsack <= 2'b00;
      r_cpu_berr  <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_dma_err   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_streak    <= w_nxt_streak;
      r_mem_ncs   <= w_nxt_mem_ncs;
      r_mem_nas   <= w_nxt_mem_nas;
      r_mem_rnw   <= w_nxt_mem_rnw;
      r_mem_siz   <= w_nxt_mem_siz;
      r_mem_addr  <= w_nxt_mem_addr;
      r_cpu_dsack <= w_nxt_cpu_dsack;
      r_cpu_berr  <= w_nxt_cpu_berr;
      r_dma_ack   <= w_nxt_dma_ack;
      r_dma_err   <= w_nxt_dma_err;
    end
  end

  assign mem_nCS   = r_mem_ncs;
  assign mem_nAS   = r_mem_nas;
  assign mem_RnW   = r_mem_rnw;
  assign mem_SIZ   = r_mem_siz;
  assign mem_ADDR  = r_mem_addr;
  assign cpu_DSACK = r_cpu_dsack;
  assign cpu_BERR  = r_cpu_berr;
  assign dma_ack   = r_dma_ack;
  assign dma_err   = r_dma_err;

endmodule

// File: tb/tb_dram_arb.sv
// Directed, table-driven bench for dram_arb plus hand-written sequences for
// contention, timeouts and asynchronous reset.
module tb_dram_arb;

  logic        CLK;
  logic        nRST;
  logic        cpu_nCS, cpu_nAS, cpu_RnW;
  logic [1:0]  cpu_SIZ;
  logic [27:0] cpu_ADDR;
  logic [1:0]  cpu_DSACK;
  logic        cpu_BERR;
  logic        dma_req, dma_RnW;
  logic [27:0] dma_ADDR;
  logic        dma_ack, dma_err;
  logic        mem_nCS, mem_nAS, mem_RnW;
  logic [1:0]  mem_SIZ;
  logic [27:0] mem_ADDR;
  logic [1:0]  mem_DSACK;

  int n_cmp;
  int n_err;

  localparam logic [27:0] A_CPU   = 28'h0001000;
  localparam logic [27:0] A_DMA   = 28'h0200000;
  localparam logic [27:0] A_ABORT = 28'h0ABCDEF;
  localparam logic [27:0] A_CONT  = 28'h0300000;

  dram_arb #(
    .MAX_CPU_STREAK (4),
    .TIMEOUT_CYC    (255)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cpu_nCS   (cpu_nCS),
    .cpu_nAS   (cpu_nAS),
    .cpu_RnW   (cpu_RnW),
    .cpu_SIZ   (cpu_SIZ),
    .cpu_ADDR  (cpu_ADDR),
    .cpu_DSACK (cpu_DSACK),
    .cpu_BERR  (cpu_BERR),
    .dma_req   (dma_req),
    .dma_RnW   (dma_RnW),
    .dma_ADDR  (dma_ADDR),
    .dma_ack   (dma_ack),
    .dma_err   (dma_err),
    .mem_nCS   (mem_nCS),
    .mem_nAS   (mem_nAS),
    .mem_RnW   (mem_RnW),
    .mem_SIZ   (mem_SIZ),
    .mem_ADDR  (mem_ADDR),
    .mem_DSACK (mem_DSACK)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        cncs;
    logic        cnas;
    logic        crnw;
    logic [1:0]  csiz;
    logic [27:0] caddr;
    logic        dreq;
    logic        drnw;
    logic [27:0] daddr;
    logic [1:0]  dsack;
    logic [37:0] exp;
  } vec_t;

  vec_t vt[$];

  // Packs the observable outputs in a fixed order for whole-vector compares.
  function automatic logic [37:0] eo(input logic ncs, input logic nas, input logic rnw,
                                     input logic [1:0] siz, input logic [27:0] addr,
                                     input logic [1:0] dsk, input logic berr,
                                     input logic ack, input logic err);
    return {ncs, nas, rnw, siz, addr, dsk, berr, ack, err};
  endfunction

  function automatic logic [37:0] outs();
    return {mem_nCS, mem_nAS, mem_RnW, mem_SIZ, mem_ADDR, cpu_DSACK, cpu_BERR, dma_ack, dma_err};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input string nm, input logic cncs, input logic cnas, input logic crnw,
                     input logic [1:0] csiz, input logic [27:0] caddr, input logic dreq,
                     input logic drnw, input logic [27:0] daddr, input logic [1:0] dsack,
                     input logic [37:0] exp);
    vec_t v;
    v.name = nm; v.cncs = cncs; v.cnas = cnas; v.crnw = crnw; v.csiz = csiz;
    v.caddr = caddr; v.dreq = dreq; v.drnw = drnw; v.daddr = daddr; v.dsack = dsack;
    v.exp = exp;
    vt.push_back(v);
  endtask

  task automatic cpu_idle();
    cpu_nCS = 1'b1;
    cpu_nAS = 1'b1;
  endtask

  initial begin
    int n;
    int acks;
    logic [37:0] rst_vec;

    n_cmp = 0;
    n_err = 0;
    rst_vec = eo(1'b1, 1'b1, 1'b1, 2'b00, 28'h0, 2'b00, 1'b0, 1'b0, 1'b0);

    nRST = 1'b0;
    cpu_nCS = 1'b1; cpu_nAS = 1'b1; cpu_RnW = 1'b1; cpu_SIZ = 2'b00; cpu_ADDR = 28'h0;
    dma_req = 1'b0; dma_RnW = 1'b1; dma_ADDR = 28'h0; mem_DSACK = 2'b00;

    // CPU read with a partial DSACK, hold after DSACK, then release blocked while DSACK high.
    add("cpu_grant",   1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 1'b0, 1'b1, 28'h0, 2'b00,
        eo(1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 2'b00, 1'b0, 1'b0, 1'b0));
    add("cpu_partial", 1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 1'b0, 1'b1, 28'h0, 2'b01,
        eo(1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 2'b01, 1'b0, 1'b0, 1'b0));
    add("cpu_dsack",   1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 1'b0, 1'b1, 28'h0, 2'b11,
        eo(1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 2'b11, 1'b0, 1'b0, 1'b0));
    add("cpu_hold",    1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 1'b0, 1'b1, 28'h0, 2'b11,
        eo(1'b0, 1'b0, 1'b1, 2'b10, A_CPU, 2'b11, 1'b0, 1'b0, 1'b0));
    add("cpu_release", 1'b1, 1'b1, 1'b1, 2'b10, A_CPU, 1'b0, 1'b1, 28'h0, 2'b11,
        eo(1'b1, 1'b1, 1'b1, 2'b10, A_CPU, 2'b00, 1'b0, 1'b0, 1'b0));
    add("rel_block",   1'b0, 1'b0, 1'b1, 2'b00, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b11,
        eo(1'b1, 1'b1, 1'b1, 2'b10, A_CPU, 2'b00, 1'b0, 1'b0, 1'b0));
    add("rel_to_idle", 1'b1, 1'b1, 1'b1, 2'b00, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b00,
        eo(1'b1, 1'b1, 1'b1, 2'b10, A_CPU, 2'b00, 1'b0, 1'b0, 1'b0));
    add("idle",        1'b1, 1'b1, 1'b1, 2'b00, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b00,
        eo(1'b1, 1'b1, 1'b1, 2'b10, A_CPU, 2'b00, 1'b0, 1'b0, 1'b0));
    // DMA write: always long-word, single ack pulse, no CPU DSACK.
    add("dma_grant",   1'b1, 1'b1, 1'b1, 2'b11, A_ABORT, 1'b1, 1'b0, A_DMA, 2'b00,
        eo(1'b0, 1'b0, 1'b0, 2'b00, A_DMA, 2'b00, 1'b0, 1'b0, 1'b0));
    add("dma_wait",    1'b1, 1'b1, 1'b1, 2'b11, A_ABORT, 1'b1, 1'b0, A_DMA, 2'b00,
        eo(1'b0, 1'b0, 1'b0, 2'b00, A_DMA, 2'b00, 1'b0, 1'b0, 1'b0));
    add("dma_done",    1'b1, 1'b1, 1'b1, 2'b11, A_ABORT, 1'b1, 1'b0, A_DMA, 2'b11,
        eo(1'b1, 1'b1, 1'b0, 2'b00, A_DMA, 2'b00, 1'b0, 1'b1, 1'b0));
    add("dma_ack_end", 1'b1, 1'b1, 1'b1, 2'b11, A_ABORT, 1'b0, 1'b0, A_DMA, 2'b11,
        eo(1'b1, 1'b1, 1'b0, 2'b00, A_DMA, 2'b00, 1'b0, 1'b0, 1'b0));
    add("dma_idle",    1'b1, 1'b1, 1'b1, 2'b11, A_ABORT, 1'b0, 1'b0, A_DMA, 2'b00,
        eo(1'b1, 1'b1, 1'b0, 2'b00, A_DMA, 2'b00, 1'b0, 1'b0, 1'b0));
    // Aborted CPU cycle: DSACK is never forwarded once nAS is high.
    add("abort_grant", 1'b0, 1'b0, 1'b0, 2'b01, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b00,
        eo(1'b0, 1'b0, 1'b0, 2'b01, A_ABORT, 2'b00, 1'b0, 1'b0, 1'b0));
    add("abort_nas",   1'b1, 1'b1, 1'b0, 2'b01, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b10,
        eo(1'b0, 1'b0, 1'b0, 2'b01, A_ABORT, 2'b00, 1'b0, 1'b0, 1'b0));
    add("abort_done",  1'b1, 1'b1, 1'b0, 2'b01, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b11,
        eo(1'b1, 1'b1, 1'b0, 2'b01, A_ABORT, 2'b00, 1'b0, 1'b0, 1'b0));
    add("abort_idle",  1'b1, 1'b1, 1'b0, 2'b01, A_ABORT, 1'b0, 1'b1, 28'h0, 2'b00,
        eo(1'b1, 1'b1, 1'b0, 2'b01, A_ABORT, 2'b00, 1'b0, 1'b0, 1'b0));

    #50;
    chk("reset_state", 64'(outs()), 64'(rst_vec));
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      cpu_nCS = vt[i].cncs; cpu_nAS = vt[i].cnas; cpu_RnW = vt[i].crnw;
      cpu_SIZ = vt[i].csiz; cpu_ADDR = vt[i].caddr;
      dma_req = vt[i].dreq; dma_RnW = vt[i].drnw; dma_ADDR = vt[i].daddr;
      mem_DSACK = vt[i].dsack;
      tick();
      chk(vt[i].name, 64'(outs()), 64'(vt[i].exp));
    end

    // Contention: four CPU grants, one forced DMA grant, then CPU again.
    for (int g = 0; g < 6; g++) begin
      cpu_nCS = 1'b0; cpu_nAS = 1'b0; cpu_RnW = 1'b1; cpu_SIZ = 2'b00;
      cpu_ADDR = A_CONT + 28'(g);
      dma_req = 1'b1; dma_RnW = 1'b1; dma_ADDR = A_DMA;
      mem_DSACK = 2'b00;
      tick();
      chk($sformatf("contend_winner_%0d", g), 64'(mem_ADDR), (g == 4) ? 64'(A_DMA) : 64'(A_CONT + 28'(g)));
      cpu_idle();
      mem_DSACK = 2'b11;
      tick();
      chk($sformatf("contend_ack_%0d", g), 64'(dma_ack), (g == 4) ? 64'd1 : 64'd0);
      mem_DSACK = 2'b00;
      tick();
    end
    dma_req = 1'b0;
    tick();

    // DMA timeout with DSACK held low.
    dma_req = 1'b1; dma_RnW = 1'b0; dma_ADDR = A_DMA; mem_DSACK = 2'b00;
    tick();
    n = 0;
    acks = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (dma_ack) acks++;
      if (dma_err) begin
        n = k;
        break;
      end
    end
    chk("dma_timeout_cycles", 64'(n), 64'd256);
    chk("dma_timeout_nas", 64'(mem_nAS), 64'd1);
    chk("dma_timeout_noack", 64'(acks), 64'd0);
    dma_req = 1'b0;
    tick();
    chk("dma_err_single", 64'({dma_err, dma_ack}), 64'd0);
    tick();

    // CPU timeout: BERR holds until the CPU drops nAS.
    cpu_nCS = 1'b0; cpu_nAS = 1'b0; cpu_ADDR = A_CPU; mem_DSACK = 2'b00;
    tick();
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (cpu_BERR) begin
        n = k;
        break;
      end
    end
    chk("cpu_timeout_cycles", 64'(n), 64'd256);
    chk("cpu_timeout_nas", 64'({mem_nCS, mem_nAS, cpu_DSACK}), 64'b1100);
    tick(); tick(); tick();
    chk("cpu_berr_held", 64'(cpu_BERR), 64'd1);
    chk("cpu_berr_no_regrant", 64'(mem_nAS), 64'd1);
    cpu_idle();
    tick();
    chk("cpu_berr_clear", 64'(cpu_BERR), 64'd0);
    tick();

    // Asynchronous reset in the middle of a DMA cycle.
    dma_req = 1'b1; dma_RnW = 1'b0; dma_ADDR = A_DMA; mem_DSACK = 2'b00;
    tick();
    tick();
    chk("pre_reset_busy", 64'(mem_nAS), 64'd0);
    #10;
    nRST = 1'b0;
    #1;
    chk("async_reset", 64'(outs()), 64'(rst_vec));
    dma_req = 1'b0;
    mem_DSACK = 2'b11;
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_reset_%0d", k), 64'(outs()), 64'(rst_vec));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
